// File: rtl/rk4_step_sequencer_pkg.sv
// Shared types and fixed-point constants for the RK4 step sequencer.
// All constants are derived from the fixed-point format and the step-size shift.
package rk4_step_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStage,
    StUpdate,
    StFin
  } rk_state_e;

  // Stage index 0..3 stands for RK4 stages k1..k4.
  typedef logic [1:0] stage_idx_t;

  localparam stage_idx_t StageK1 = 2'd0;
  localparam stage_idx_t StageK2 = 2'd1;
  localparam stage_idx_t StageK3 = 2'd2;
  localparam stage_idx_t StageK4 = 2'd3;

  // round(2^frac / 6)
  function automatic longint unsigned c_sixth(input int unsigned frac);
    return ((64'd1 << frac) + 64'd3) / 64'd6;
  endfunction

  function automatic longint unsigned h_step(input int unsigned frac, input int unsigned hs);
    return 64'd1 << (frac - hs);
  endfunction

  function automatic longint unsigned h_half(input int unsigned frac, input int unsigned hs);
    return 64'd1 << (frac - hs - 1);
  endfunction

endpackage

// File: rtl/rk4_weight_accum.sv
// Combinational RK4 combine: weighted slope sum, scaled by h/6, plus the time advance.
module rk4_weight_accum
  import rk4_step_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned H_SHIFT = 4
) (
  input  logic signed [WIDTH-1:0] k1,
  input  logic signed [WIDTH-1:0] k2,
  input  logic signed [WIDTH-1:0] k3,
  input  logic signed [WIDTH-1:0] k4,
  input  logic signed [WIDTH-1:0] t,
  input  logic signed [WIDTH-1:0] y,
  output logic signed [WIDTH-1:0] y_next,
  output logic signed [WIDTH-1:0] t_next
);

  localparam int unsigned SW = WIDTH + 3;
  localparam int unsigned PW = 2 * WIDTH + 3;

  localparam logic signed [PW-1:0]    CSixth = PW'(c_sixth(FRAC));
  localparam logic signed [WIDTH-1:0] HStep  = WIDTH'(h_step(FRAC, H_SHIFT));

  logic signed [SW-1:0] s_sum;
  logic signed [SW-1:0] s_scaled;

  always_comb begin
    s_sum    = SW'(k1) + (SW'(k2) <<< 1) + (SW'(k3) <<< 1) + SW'(k4);
    s_scaled = s_sum >>> H_SHIFT;
    // Multiply by round(2^FRAC/6) then drop FRAC bits: approximates S*h/6 in fixed point.
    y_next   = y + WIDTH'((PW'(s_scaled) * CSixth) >>> FRAC);
    t_next   = t + HStep;
  end

endmodule

// File: rtl/rk4_step_sequencer.sv
// Sequences the four RK4 evaluator calls per step and forms y_next for N consecutive steps.
// Evaluator arguments are held for F_LATENCY+1 cycles; its result is captured on the last one.
module rk4_step_sequencer
  import rk4_step_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC      = 16,
  parameter int unsigned H_SHIFT   = 4,
  parameter int unsigned F_LATENCY = 1,
  parameter int unsigned NW        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_t0,
  input  logic [WIDTH-1:0] i_y0,
  input  logic [NW-1:0]    i_nsteps,
  output logic [WIDTH-1:0] o_f_x,
  output logic [WIDTH-1:0] o_f_y,
  input  logic [WIDTH-1:0] i_f_val,
  output logic [WIDTH-1:0] o_y,
  output logic [WIDTH-1:0] o_t,
  output logic             o_y_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CW = $clog2(F_LATENCY + 1);
  localparam logic [CW-1:0] CycLast = CW'(F_LATENCY);

  localparam logic signed [WIDTH-1:0] HStep = WIDTH'(h_step(FRAC, H_SHIFT));
  localparam logic signed [WIDTH-1:0] HHalf = WIDTH'(h_half(FRAC, H_SHIFT));

  rk_state_e  state_q;
  stage_idx_t stage_q;
  logic [CW-1:0] cyc_q;
  logic [NW-1:0] n_q;
  logic signed [WIDTH-1:0] t_q, y_q;
  logic signed [WIDTH-1:0] k1_q, k2_q, k3_q, k4_q;
  logic signed [WIDTH-1:0] y_next, t_next;
  logic signed [WIDTH-1:0] fval;

  assign fval = $signed(i_f_val);

  rk4_weight_accum #(
    .WIDTH  (WIDTH),
    .FRAC   (FRAC),
    .H_SHIFT(H_SHIFT)
  ) u_accum (
    .k1    (k1_q),
    .k2    (k2_q),
    .k3    (k3_q),
    .k4    (k4_q),
    .t     (t_q),
    .y     (y_q),
    .y_next(y_next),
    .t_next(t_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      stage_q   <= StageK1;
      cyc_q     <= '0;
      n_q       <= '0;
      t_q       <= '0;
      y_q       <= '0;
      k1_q      <= '0;
      k2_q      <= '0;
      k3_q      <= '0;
      k4_q      <= '0;
      o_f_x     <= '0;
      o_f_y     <= '0;
      o_y       <= '0;
      o_t       <= '0;
      o_y_valid <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_y_valid <= 1'b0;
      o_done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            t_q <= $signed(i_t0);
            y_q <= $signed(i_y0);
            n_q <= i_nsteps;
            if (i_nsteps == '0) begin
              state_q <= StFin;
              o_done  <= 1'b1;
            end else begin
              state_q <= StStage;
              stage_q <= StageK1;
              cyc_q   <= '0;
              o_f_x   <= i_t0;
              o_f_y   <= i_y0;
              o_busy  <= 1'b1;
            end
          end
        end
        StStage: begin
          if (cyc_q == CycLast) begin
            cyc_q   <= '0;
            stage_q <= stage_q + 2'd1;
            // Next stage's arguments come straight from the slope being captured now.
            unique case (stage_q)
              StageK1: begin
                k1_q  <= fval;
                o_f_x <= t_q + HHalf;
                o_f_y <= y_q + (fval >>> (H_SHIFT + 1));
              end
              StageK2: begin
                k2_q  <= fval;
                o_f_x <= t_q + HHalf;
                o_f_y <= y_q + (fval >>> (H_SHIFT + 1));
              end
              StageK3: begin
                k3_q  <= fval;
                o_f_x <= t_q + HStep;
                o_f_y <= y_q + (fval >>> H_SHIFT);
              end
              StageK4: begin
                k4_q    <= fval;
                state_q <= StUpdate;
              end
              default: state_q <= StIdle;
            endcase
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        StUpdate: begin
          y_q       <= y_next;
          t_q       <= t_next;
          o_y       <= y_next;
          o_t       <= t_next;
          o_y_valid <= 1'b1;
          n_q       <= n_q - NW'(1);
          if (n_q == NW'(1)) begin
            state_q <= StFin;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            state_q <= StStage;
            stage_q <= StageK1;
            cyc_q   <= '0;
            o_f_x   <= t_next;
            o_f_y   <= y_next;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rk4_step_sequencer.sv
// Directed bench for rk4_step_sequencer with a registered f(x,y) = x + y evaluator.
module tb_rk4_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_t0, i_y0;
  logic [15:0] i_nsteps;
  logic [31:0] o_f_x, o_f_y, i_f_val, o_y, o_t;
  logic        o_y_valid, o_busy, o_done;

  always #5 clk = ~clk;

  // Evaluator model: one-cycle registered x + y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) i_f_val <= '0;
    else     i_f_val <= o_f_x + o_f_y;
  end

  rk4_step_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_t0     (i_t0),
    .i_y0     (i_y0),
    .i_nsteps (i_nsteps),
    .o_f_x    (o_f_x),
    .o_f_y    (o_f_y),
    .i_f_val  (i_f_val),
    .o_y      (o_y),
    .o_t      (o_t),
    .o_y_valid(o_y_valid),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] t0;
    logic [31:0] y0;
    logic [15:0] n;
    logic [31:0] ey;
    logic [31:0] et;
    int          pulses;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] exp_fx[8];
  logic [31:0] exp_fy[8];
  logic [31:0] exp_step_y[4];
  logic [31:0] exp_step_t[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  task automatic pulse_start(input logic [31:0] t0, input logic [31:0] y0, input logic [15:0] n);
    @(negedge clk);
    i_t0     = t0;
    i_y0     = y0;
    i_nsteps = n;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
  endtask

  // Sample index idx = number of rising edges since the start-accepting edge.
  task automatic run_vec(input int r);
    int idx     = 0;
    int pulses  = 0;
    bit done_ok = 0;
    pulse_start(vecs[r].t0, vecs[r].y0, vecs[r].n);
    check("busy_after_start", {31'd0, o_busy}, {31'd0, vecs[r].n != 16'd0});
    while (idx < 200 && !done_ok) begin
      if (r == 0 && idx < 8) begin
        check($sformatf("stage_fx[%0d]", idx), o_f_x, exp_fx[idx]);
        check($sformatf("stage_fy[%0d]", idx), o_f_y, exp_fy[idx]);
      end
      if (o_y_valid) begin
        pulses++;
        check("valid_cycle", idx, 9 * pulses);
        if (r == 3 && pulses <= 4) begin
          check($sformatf("step_y[%0d]", pulses), o_y, exp_step_y[pulses-1]);
          check($sformatf("step_t[%0d]", pulses), o_t, exp_step_t[pulses-1]);
        end
      end
      if (o_done) done_ok = 1;
      else begin
        @(negedge clk);
        idx++;
      end
    end
    check("done_seen", {31'd0, done_ok}, 32'd1);
    check("done_cycle", idx, 9 * int'(vecs[r].n));
    check("pulse_count", pulses, vecs[r].pulses);
    check("final_y", o_y, vecs[r].ey);
    check("final_t", o_t, vecs[r].et);
    check("busy_at_done", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, o_done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fx"}, o_f_x, 32'd0);
    check({tag, "_fy"}, o_f_y, 32'd0);
    check({tag, "_y"}, o_y, 32'd0);
    check({tag, "_t"}, o_t, 32'd0);
    check({tag, "_flags"}, {29'd0, o_y_valid, o_busy, o_done}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{t0: 32'h0000_0000, y0: 32'h0001_0000, n: 16'd1,
                ey: 32'h0001_1105, et: 32'h0000_1000, pulses: 1};
    vecs[1] = '{t0: 32'h0000_0000, y0: 32'h0000_0000, n: 16'd1,
                ey: 32'h0000_0082, et: 32'h0000_1000, pulses: 1};
    vecs[2] = '{t0: 32'h0001_0000, y0: 32'hFFFE_0000, n: 16'd1,
                ey: 32'hFFFD_EFFF, et: 32'h0001_1000, pulses: 1};
    vecs[3] = '{t0: 32'h0000_0000, y0: 32'h0001_0000, n: 16'd4,
                ey: 32'h0001_516A, et: 32'h0000_4000, pulses: 4};
    // n=0 leaves o_y/o_t at the previous run's results.
    vecs[4] = '{t0: 32'h0000_5000, y0: 32'h0000_7777, n: 16'd0,
                ey: 32'h0001_516A, et: 32'h0000_4000, pulses: 0};
    exp_fx     = '{32'h0, 32'h0, 32'h800, 32'h800, 32'h800, 32'h800, 32'h1000, 32'h1000};
    exp_fy     = '{32'h1_0000, 32'h1_0000, 32'h1_0800, 32'h1_0800,
                   32'h1_0880, 32'h1_0880, 32'h1_1108, 32'h1_1108};
    exp_step_y = '{32'h0001_1105, 32'h0001_242B, 32'h0001_3996, 32'h0001_516A};
    exp_step_t = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};

    rst      = 1'b1;
    i_start  = 1'b0;
    i_t0     = '0;
    i_y0     = '0;
    i_nsteps = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < 5; r++) run_vec(r);

    // Start pulses during stage 3 and during the o_done cycle must both be ignored.
    begin
      int pulses   = 0;
      int done_idx = -1;
      pulse_start(32'h0, 32'h0001_0000, 16'd1);
      i_t0     = 32'h0000_7000;
      i_y0     = 32'h0;
      i_nsteps = 16'd5;
      for (int i = 0; i < 14; i++) begin
        if (o_y_valid) pulses++;
        if (o_done) done_idx = i;
        if (i >= 10) check($sformatf("busy_after_ignored[%0d]", i), {31'd0, o_busy}, 32'd0);
        i_start = (i == 4 || i == 9);
        @(negedge clk);
      end
      i_start = 1'b0;
      check("ignored_start_done_cycle", done_idx, 9);
      check("ignored_start_pulses", pulses, 1);
      check("ignored_start_y", o_y, 32'h0001_1105);
      check("ignored_start_t", o_t, 32'h0000_1000);
    end

    // Reset in the middle of stage 2 aborts the run without o_done.
    begin
      int seen = 0;
      pulse_start(32'h0, 32'h0001_0000, 16'd4);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      check_all_zero("rst_next_cycle");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (o_done || o_y_valid || o_busy) seen++;
        @(negedge clk);
      end
      check("no_activity_after_abort", seen, 0);
    end

    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
